// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, BRAM port, and the IF/ID register out.
// The fetch stage is the master; the surrounding pipeline and BRAM act as slave.
interface if_fetch_stage_if #(
  parameter int unsigned IMEM_AW = 14
);
  logic               PcWrite;
  logic               IF_ID_Write;
  logic               Redirect;
  logic [31:0]        RedirectPc;
  logic               ImemEn;
  logic [IMEM_AW-1:0] ImemAddr;
  logic [31:0]        ImemData;
  logic [31:0]        PcF;
  logic [31:0]        IfIdPc;
  logic [31:0]        IfIdInst;
  logic               IfIdValid;

  modport master (
    input  PcWrite, IF_ID_Write, Redirect, RedirectPc, ImemData,
    output ImemEn, ImemAddr, PcF, IfIdPc, IfIdInst, IfIdValid
  );

  modport slave (
    output PcWrite, IF_ID_Write, Redirect, RedirectPc, ImemData,
    input  ImemEn, ImemAddr, PcF, IfIdPc, IfIdInst, IfIdValid
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction Fetch stage with IF/ID pipeline register. Owns the PC, addresses a
// 1-cycle-latency instruction BRAM with the next PC, and squashes on EX redirects.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 14,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  if_fetch_stage_if.master       bus
);

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] if_id_pc_q;
  logic [31:0] if_id_inst_q;
  logic        if_id_valid_q;
  logic        adv;

  // Either hazard-unit enable low freezes both PC and IF/ID together.
  assign adv = bus.PcWrite & bus.IF_ID_Write;

  always_comb begin
    pc_d = pc_q;
    if (state_q == S_RUN) begin
      if (bus.Redirect) begin
        pc_d = bus.RedirectPc & ~32'd3;
      end else if (adv) begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  // BRAM is addressed with the next PC so its data lines up with pc_q each cycle;
  // on hold the same word is re-read, keeping ImemData stable.
  assign bus.ImemEn   = ~rst;
  assign bus.ImemAddr = rst ? RESET_PC[IMEM_AW+1:2] : pc_d[IMEM_AW+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      if_id_pc_q    <= '0;
      if_id_inst_q  <= NOP_INST;
      if_id_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          state_q       <= S_RUN;
          if_id_pc_q    <= pc_q;
          if_id_inst_q  <= NOP_INST;
          if_id_valid_q <= 1'b0;
        end
        S_RUN: begin
          if (bus.Redirect) begin
            if_id_pc_q    <= pc_q;
            if_id_inst_q  <= NOP_INST;
            if_id_valid_q <= 1'b0;
          end else if (adv) begin
            if_id_pc_q    <= pc_q;
            if_id_inst_q  <= bus.ImemData;
            if_id_valid_q <= 1'b1;
          end
        end
        default: state_q <= S_BOOT;
      endcase
      pc_q <= pc_d;
    end
  end

  assign bus.PcF       = pc_q;
  assign bus.IfIdPc    = if_id_pc_q;
  assign bus.IfIdInst  = if_id_inst_q;
  assign bus.IfIdValid = if_id_valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; the BRAM model returns 0x1000 + word address.
module tb_if_fetch_stage;
  localparam int unsigned AW = 14;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  if_fetch_stage_if #(.IMEM_AW(AW)) bus ();

  if_fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .IMEM_AW (AW),
    .NOP_INST(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ImemEn) bus.ImemData <= 32'h1000 + 32'(bus.ImemAddr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pw, input logic iw, input logic rd, input logic [31:0] tgt);
    bus.PcWrite     = pw;
    bus.IF_ID_Write = iw;
    bus.Redirect    = rd;
    bus.RedirectPc  = tgt;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    rst = 1'b1;
    tick(); tick();
    n_chk++; if (bus.IfIdValid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.IfIdValid); else n_pass++;
    n_chk++; if (bus.IfIdInst !== NOP) $display("FAIL rst_inst: got %h want %h", bus.IfIdInst, NOP); else n_pass++;
    n_chk++; if (bus.IfIdPc !== 32'h0) $display("FAIL rst_pc: got %h want 0", bus.IfIdPc); else n_pass++;
    n_chk++; if (bus.ImemEn !== 1'b0) $display("FAIL rst_en: got %b want 0", bus.ImemEn); else n_pass++;
    n_chk++; if (bus.ImemAddr !== 14'h0) $display("FAIL rst_addr: got %h want 0", bus.ImemAddr); else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++; if (bus.ImemEn !== 1'b1) $display("FAIL boot_en: got %b want 1", bus.ImemEn); else n_pass++;
  endtask

  // Starts right after reset release; ends with IF/ID holding PC 8.
  task automatic test_sequence(input string tag);
    tick();
    n_chk++; if (bus.IfIdValid !== 1'b0) $display("FAIL %s_boot_valid: got %b want 0", tag, bus.IfIdValid); else n_pass++;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (bus.IfIdValid !== 1'b1) $display("FAIL %s_valid%0d: got %b want 1", tag, i, bus.IfIdValid); else n_pass++;
      n_chk++; if (bus.IfIdPc !== 32'(4 * i)) $display("FAIL %s_pc%0d: got %h want %h", tag, i, bus.IfIdPc, 32'(4 * i)); else n_pass++;
      n_chk++; if (bus.IfIdInst !== 32'h1000 + i) $display("FAIL %s_inst%0d: got %h want %h", tag, i, bus.IfIdInst, 32'h1000 + i); else n_pass++;
    end
  endtask

  task automatic test_stall();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (bus.IfIdPc !== 32'h8) $display("FAIL stall_pc%0d: got %h want 8", i, bus.IfIdPc); else n_pass++;
      n_chk++; if (bus.IfIdInst !== 32'h1002) $display("FAIL stall_inst%0d: got %h want 1002", i, bus.IfIdInst); else n_pass++;
      n_chk++; if (bus.PcF !== 32'hC) $display("FAIL stall_pcf%0d: got %h want c", i, bus.PcF); else n_pass++;
    end
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    n_chk++; if (bus.IfIdPc !== 32'hC) $display("FAIL unstall_pc: got %h want c", bus.IfIdPc); else n_pass++;
    n_chk++; if (bus.IfIdInst !== 32'h1003) $display("FAIL unstall_inst: got %h want 1003", bus.IfIdInst); else n_pass++;
    tick();
    n_chk++; if (bus.IfIdPc !== 32'h10) $display("FAIL adv_pc10: got %h want 10", bus.IfIdPc); else n_pass++;
  endtask

  // Entered with IF/ID at PC 0x10 and F stage at 0x14.
  task automatic test_redirect();
    drive(1'b1, 1'b1, 1'b1, 32'h40);
    tick();
    n_chk++; if (bus.IfIdValid !== 1'b0) $display("FAIL redir_bub_valid: got %b want 0", bus.IfIdValid); else n_pass++;
    n_chk++; if (bus.IfIdInst !== NOP) $display("FAIL redir_bub_inst: got %h want %h", bus.IfIdInst, NOP); else n_pass++;
    n_chk++; if (bus.IfIdPc !== 32'h14) $display("FAIL redir_bub_pc: got %h want 14", bus.IfIdPc); else n_pass++;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    n_chk++; if (bus.IfIdPc !== 32'h40) $display("FAIL redir_pc: got %h want 40", bus.IfIdPc); else n_pass++;
    n_chk++; if (bus.IfIdInst !== 32'h1010) $display("FAIL redir_inst: got %h want 1010", bus.IfIdInst); else n_pass++;
    n_chk++; if (bus.IfIdValid !== 1'b1) $display("FAIL redir_valid: got %b want 1", bus.IfIdValid); else n_pass++;
  endtask

  task automatic test_redirect_stall();
    drive(1'b0, 1'b0, 1'b1, 32'h83);
    tick();
    n_chk++; if (bus.PcF !== 32'h80) $display("FAIL rs_pcf: got %h want 80", bus.PcF); else n_pass++;
    n_chk++; if (bus.IfIdValid !== 1'b0) $display("FAIL rs_bub_valid: got %b want 0", bus.IfIdValid); else n_pass++;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    n_chk++; if (bus.IfIdPc !== 32'h80) $display("FAIL rs_pc: got %h want 80", bus.IfIdPc); else n_pass++;
    n_chk++; if (bus.IfIdInst !== 32'h1020) $display("FAIL rs_inst: got %h want 1020", bus.IfIdInst); else n_pass++;
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    #1;
    n_chk++; if (bus.ImemAddr !== 14'h3FFF) $display("FAIL wrap_addr_tgt: got %h want 3fff", bus.ImemAddr); else n_pass++;
    tick();
    n_chk++; if (bus.PcF !== 32'hFFFF_FFFC) $display("FAIL wrap_pcf: got %h want fffffffc", bus.PcF); else n_pass++;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    n_chk++; if (bus.ImemAddr !== 14'h0) $display("FAIL wrap_addr_next: got %h want 0", bus.ImemAddr); else n_pass++;
    tick();
    n_chk++; if (bus.IfIdPc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc_top: got %h want fffffffc", bus.IfIdPc); else n_pass++;
    n_chk++; if (bus.IfIdInst !== 32'h4FFF) $display("FAIL wrap_inst_top: got %h want 4fff", bus.IfIdInst); else n_pass++;
    tick();
    n_chk++; if (bus.IfIdPc !== 32'h0) $display("FAIL wrap_pc_zero: got %h want 0", bus.IfIdPc); else n_pass++;
    n_chk++; if (bus.IfIdInst !== 32'h1000) $display("FAIL wrap_inst_zero: got %h want 1000", bus.IfIdInst); else n_pass++;
  endtask

  // IF/ID holds PC 0 on entry; advance to 0x24, then reset asynchronously.
  task automatic test_midrun_reset();
    repeat (9) tick();
    n_chk++; if (bus.IfIdPc !== 32'h24) $display("FAIL mr_pre_pc: got %h want 24", bus.IfIdPc); else n_pass++;
    n_chk++; if (bus.IfIdValid !== 1'b1) $display("FAIL mr_pre_valid: got %b want 1", bus.IfIdValid); else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++; if (bus.IfIdValid !== 1'b0) $display("FAIL mr_valid: got %b want 0", bus.IfIdValid); else n_pass++;
    n_chk++; if (bus.IfIdPc !== 32'h0) $display("FAIL mr_pc: got %h want 0", bus.IfIdPc); else n_pass++;
    n_chk++; if (bus.IfIdInst !== NOP) $display("FAIL mr_inst: got %h want %h", bus.IfIdInst, NOP); else n_pass++;
    n_chk++; if (bus.PcF !== 32'h0) $display("FAIL mr_pcf: got %h want 0", bus.PcF); else n_pass++;
    n_chk++; if (bus.ImemEn !== 1'b0) $display("FAIL mr_en: got %b want 0", bus.ImemEn); else n_pass++;
    tick();
    rst = 1'b0;
    test_sequence("mr");
  endtask

  task automatic test_boot_redirect();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 32'h100);
    tick();
    n_chk++; if (bus.PcF !== 32'h0) $display("FAIL boot_redir_pcf: got %h want 0", bus.PcF); else n_pass++;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    n_chk++; if (bus.IfIdPc !== 32'h0) $display("FAIL boot_redir_pc: got %h want 0", bus.IfIdPc); else n_pass++;
    n_chk++; if (bus.IfIdInst !== 32'h1000) $display("FAIL boot_redir_inst: got %h want 1000", bus.IfIdInst); else n_pass++;
  endtask

  initial begin
    bus.ImemData = '0;
    test_reset();
    test_sequence("seq");
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_midrun_reset();
    test_boot_redirect();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
